pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline stall/flush controller: the generalised successor of the fixed five-stage control unit. Per-stage stall and redirect requests for `NUM_STAGES` pipeline boundaries are resolved into per-boundary `stall` and `flush` vectors, with automatic bubble insertion. A redirect state machine holds fetch until the PC redirect is acknowledged after an exception or refetch. Stall-cycle accounting and a no-progress watchdog are included. It sits between the hazard sources (caches, forwarding, branch unit, commit/exception logic) and every pipeline register.

---
 rtl/gemini_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gemini_ctrl_pkg.sv
// rtl/gemini_ctrl_pkg.sv - shared control types and stage indices for the hazard controller
// Purpose: FSM state encoding, stage-index constants and default pipeline depth.
// Ports: none (package).
package gemini_ctrl_pkg;

  typedef enum logic [0:0] {
    CTRL_IDLE     = 1'b0,
    CTRL_REDIRECT = 1'b1
  } ctrl_state_e;

  localparam int DEFAULT_NUM_STAGES = 6;

  // Stage indices for the default six-boundary pipeline, youngest first.
  localparam int STG_PC     = 0;
  localparam int STG_IF     = 1;
  localparam int STG_ID     = 2;
  localparam int STG_EX     = 3;
  localparam int STG_MEM    = 4;
  localparam int STG_COMMIT = DEFAULT_NUM_STAGES - 1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts cycles where inc=1, sticks at all-ones, clr has priority.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   inc         : count this cycle
//   clr         : clear this cycle (wins over inc)
//   count       : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - per-boundary stall/flush resolution with redirect FSM and watchdog
// Purpose: turns per-stage stall/redirect requests into stall and flush vectors,
//   holds fetch after an exception until the redirect PC is acknowledged,
//   counts fetch-stall cycles and flags a commit stage that makes no progress.
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   stall_req      : per-stage "cannot advance" requests
//   redir_req      : per-stage redirect (younger stages squashed)
//   exc_req        : exception/refetch at commit, squash everything
//   redirect_ack   : fetch has loaded the redirect PC
//   stall, flush   : per pipeline register hold / clear (flush wins)
//   busy_redirect  : FSM waiting for redirect_ack
//   stall_cycles   : saturating count of cycles with stall[0]=1
//   wdog_timeout   : sticky no-progress flag
module pipe_hazard_ctrl
  import gemini_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] redir_req,
  input  logic                  exc_req,
  input  logic                  redirect_ack,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  busy_redirect,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  wdog_timeout
);

  localparam int TOP = NUM_STAGES - 1;

  ctrl_state_e state_q, state_d;

  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] eff_redir;
  logic [NUM_STAGES-1:0] rsq;
  logic [NUM_STAGES-1:0] bub;
  logic [NUM_STAGES-1:0] idle_flush;
  logic [NUM_STAGES-1:0] idle_stall;

  // A redirect from a stage that is itself held is dropped; the source re-presents it.
  assign eff_redir = redir_req & ~hold;

  // Shifting right by the stage index folds "all stages at or above" into one reduction.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_prefix
    assign hold[gi] = |(stall_req >> gi);
    assign rsq[gi]  = |(eff_redir >> (gi + 1));
  end

  assign bub[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_bubble
    assign bub[gi] = hold[gi-1] & ~hold[gi];
  end

  assign idle_flush = rsq | bub;
  assign idle_stall = hold & ~idle_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = '0;
    flush   = '0;
    if (!resetn) begin
      flush = '1;
    end else if (exc_req) begin
      // Commit retires the excepting slot; everything younger is squashed.
      flush      = '1;
      flush[TOP] = 1'b0;
      state_d    = CTRL_REDIRECT;
    end else if ((state_q == CTRL_REDIRECT) && !redirect_ack) begin
      stall[STG_PC] = 1'b1;
      flush         = '1;
      flush[STG_PC] = 1'b0;
      flush[TOP]    = idle_flush[TOP];
      stall[TOP]    = idle_stall[TOP];
    end else begin
      // Covers IDLE and the ack cycle, which already uses normal resolution.
      flush   = idle_flush;
      stall   = idle_stall;
      state_d = CTRL_IDLE;
    end
  end

  assign busy_redirect = (state_q == CTRL_REDIRECT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (stall[STG_PC]),
    .clr    (1'b0),
    .count  (stall_cycles)
  );

  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_clr;

  assign wdog_clr = ~stall[TOP] | (state_q == CTRL_REDIRECT);

  sat_counter #(.W(CNT_W)) u_wdog_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (1'b1),
    .clr    (wdog_clr),
    .count  (wdog_cnt)
  );

  // Set on the edge where the count reaches the limit, so the flag is visible
  // right after the WDOG_LIMIT-th stalled edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_timeout <= 1'b0;
    end else if (!wdog_clr && (wdog_cnt == CNT_W'(WDOG_LIMIT - 1))) begin
      wdog_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [N-1:0] stall_req = '0;
  logic [N-1:0] redir_req = '0;
  logic         exc_req = 1'b0;
  logic         redirect_ack = 1'b0;
  logic [N-1:0] stall;
  logic [N-1:0] flush;
  logic         busy_redirect;
  logic [3:0]   stall_cycles;
  logic         wdog_timeout;

  int n_asserts = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.NUM_STAGES(N), .CNT_W(4), .WDOG_LIMIT(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall_req     (stall_req),
    .redir_req     (redir_req),
    .exc_req       (exc_req),
    .redirect_ack  (redirect_ack),
    .stall         (stall),
    .flush         (flush),
    .busy_redirect (busy_redirect),
    .stall_cycles  (stall_cycles),
    .wdog_timeout  (wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] exp_stall, input logic [N-1:0] exp_flush);
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(exp_flush));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    stall_req = '0; redir_req = '0; exc_req = 1'b0; redirect_ack = 1'b0;
    #1;
    chk_out(tag, 6'b000000, 6'b111111);
    chk({tag, ".busy"}, 32'(busy_redirect), 32'd0);
    chk({tag, ".scyc"}, 32'(stall_cycles), 32'd0);
    chk({tag, ".wdog"}, 32'(wdog_timeout), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #2 resetn = 1'b0;
    #1;
    chk_out("rst0", 6'b000000, 6'b111111);
    chk("rst0.busy", 32'(busy_redirect), 32'd0);
    chk("rst0.scyc", 32'(stall_cycles), 32'd0);
    chk("rst0.wdog", 32'(wdog_timeout), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_out("idle0", 6'b000000, 6'b000000);

    // Stall in stage 3 -> younger held, bubble into stage 4
    stall_req = 6'b001000;
    #1;
    chk_out("stall3", 6'b001111, 6'b010000);

    // Redirect from stage 2, no stalls
    @(negedge clk);
    stall_req = 6'b000000; redir_req = 6'b000100;
    #1;
    chk_out("redir2", 6'b000000, 6'b000011);

    // Same redirect while stage 4 stalls -> ignored
    @(negedge clk);
    stall_req = 6'b010000;
    #1;
    chk_out("redir2_held", 6'b011111, 6'b100000);

    // Two effective redirects: oldest sets the range
    @(negedge clk);
    stall_req = 6'b000000; redir_req = 6'b010010;
    #1;
    chk_out("redir_multi", 6'b000000, 6'b001111);

    // Exception with every stage stalling
    @(negedge clk);
    redir_req = '0; stall_req = 6'b111111; exc_req = 1'b1;
    #1;
    chk_out("exc", 6'b000000, 6'b011111);
    chk("exc.busy", 32'(busy_redirect), 32'd0);

    // REDIRECT cycles 1..3
    @(negedge clk);
    exc_req = 1'b0; stall_req = '0;
    #1;
    chk_out("redir_c1", 6'b000001, 6'b011110);
    chk("redir_c1.busy", 32'(busy_redirect), 32'd1);
    @(negedge clk);
    stall_req = 6'b100000;
    #1;
    chk_out("redir_c2_commit", 6'b100001, 6'b011110);
    @(negedge clk);
    stall_req = '0;
    #1;
    chk_out("redir_c3", 6'b000001, 6'b011110);
    chk("redir_c3.busy", 32'(busy_redirect), 32'd1);

    // Ack on the 4th cycle -> IDLE outputs immediately
    @(negedge clk);
    redirect_ack = 1'b1;
    #1;
    chk_out("ack", 6'b000000, 6'b000000);
    chk("ack.busy", 32'(busy_redirect), 32'd1);
    @(negedge clk);
    redirect_ack = 1'b0;
    #1;
    chk("post_ack.busy", 32'(busy_redirect), 32'd0);
    chk_out("post_ack", 6'b000000, 6'b000000);

    // Ack in IDLE is ignored
    @(negedge clk);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    #1;
    chk("idle_ack.busy", 32'(busy_redirect), 32'd0);

    // exc_req + redirect_ack together in REDIRECT -> stays REDIRECT
    @(negedge clk);
    exc_req = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b1;
    #1;
    chk_out("exc_ack", 6'b000000, 6'b011111);
    @(negedge clk);
    exc_req = 1'b0; redirect_ack = 1'b0;
    #1;
    chk("exc_ack.busy", 32'(busy_redirect), 32'd1);
    chk_out("exc_ack_hold", 6'b000001, 6'b011110);
    chk("exc_ack.scyc_nonzero", 32'(stall_cycles != 4'd0), 32'd1);

    // Reset mid-REDIRECT
    do_reset("rst_mid");
    #1;
    chk("rst_mid.busy_after", 32'(busy_redirect), 32'd0);
    chk_out("rst_mid_idle", 6'b000000, 6'b000000);

    // stall_cycles saturation (CNT_W=4)
    stall_req = 6'b000001;
    repeat (5) @(posedge clk);
    #1;
    chk("scyc5", 32'(stall_cycles), 32'd5);
    repeat (15) @(posedge clk);
    #1;
    chk("scyc_sat", 32'(stall_cycles), 32'd15);
    chk("scyc.wdog", 32'(wdog_timeout), 32'd0);

    // Watchdog (WDOG_LIMIT=8)
    do_reset("rst_wd");
    stall_req = 6'b100000;
    repeat (7) @(posedge clk);
    #1;
    chk("wdog7", 32'(wdog_timeout), 32'd0);
    @(posedge clk);
    #1;
    chk("wdog8", 32'(wdog_timeout), 32'd1);
    @(negedge clk);
    stall_req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("wdog_sticky", 32'(wdog_timeout), 32'd1);
    do_reset("rst_wd_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
